// File: rtl/calc_pkg.sv
// Shared types and codes for the calculator's output-path converters.
package calc_pkg;

    // Converter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FORMAT  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Digit-driver codes
    localparam logic [3:0] SIGN_CODE  = 4'hE;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Sign-magnitude pattern that means -128 rather than -0
    localparam logic [7:0] SM_NEG128  = 8'h80;

endpackage : calc_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3

// File: rtl/binary_sm2bcd.sv
// 8-bit sign-magnitude to 4-digit signed BCD display word, iterative double-dabble.
// Optional build macro: BINARY_SM2BCD_LEADING_BLANK_EN
//   defined   -> unused leading digit positions are driven with the blank code
//   undefined -> unused leading digit positions are 4'h0
module binary_sm2bcd #(
    parameter int         ITER      = 8,
    parameter logic [3:0] SIGN_CODE = 4'hE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  binary_sm,
    output logic        busy,
    output logic        done,
    output logic [15:0] BCD
);

    import calc_pkg::*;

    localparam int             CNT_W    = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

`ifdef BINARY_SM2BCD_LEADING_BLANK_EN
    localparam logic [3:0] LEAD_CODE = BLANK_CODE;
`else
    localparam logic [3:0] LEAD_CODE = 4'h0;
`endif

    state_t           r_state;
    logic [7:0]       r_mag;
    logic             r_neg;
    logic [11:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_word;
    logic [15:0]      r_bcd;
    logic             r_busy;
    logic             r_done;

    logic [7:0]       w_mag_dec;
    logic             w_neg_dec;
    logic [11:0]      w_adj;
    logic [3:0]       w_h;
    logic [3:0]       w_t;
    logic [3:0]       w_u;
    logic [15:0]      w_word;

    // -128 has its own pattern; every other negative zero collapses to +0
    assign w_mag_dec = (binary_sm == SM_NEG128) ? 8'd128 : {1'b0, binary_sm[6:0]};
    assign w_neg_dec = (binary_sm == SM_NEG128) | (binary_sm[7] & (|binary_sm[6:0]));

    // Per-digit add-3 correction ahead of each shift
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_acc[gi*4 +: 4]),
                .o_digit (w_adj[gi*4 +: 4])
            );
        end
    endgenerate

    assign w_h = r_acc[11:8];
    assign w_t = r_acc[7:4];
    assign w_u = r_acc[3:0];

    // Place the minus sign just left of the most significant nonzero digit
    always_comb begin
        w_word = {LEAD_CODE, LEAD_CODE, LEAD_CODE, w_u};
        if (w_h != 4'd0) begin
            w_word = r_neg ? {SIGN_CODE, w_h, w_t, w_u} : {LEAD_CODE, w_h, w_t, w_u};
        end else if (w_t != 4'd0) begin
            w_word = r_neg ? {LEAD_CODE, SIGN_CODE, w_t, w_u} : {LEAD_CODE, LEAD_CODE, w_t, w_u};
        end else if (r_neg) begin
            w_word = {LEAD_CODE, LEAD_CODE, SIGN_CODE, w_u};
        end
    end

    // Sequencer: accept, shift ITER times, format, publish with a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mag   <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mag   <= w_mag_dec;
                        r_neg   <= w_neg_dec;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_acc <= {w_adj[10:0], r_mag[7]};
                    r_mag <= {r_mag[6:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FORMAT;
                    end
                end
                FORMAT: begin
                    r_word  <= w_word;
                    r_state <= DONE;
                end
                DONE: begin
                    r_bcd   <= r_word;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign BCD  = r_bcd;

endmodule : binary_sm2bcd

// File: tb/tb_binary_sm2bcd.sv
// Self-checking bench for binary_sm2bcd: scoreboard of expected display words.
module tb_binary_sm2bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  binary_sm;
    logic        busy;
    logic        done;
    logic [15:0] BCD;

    int          n_vec;
    int          n_err;
    int          n_done;
    logic [15:0] exp_q[$];

    binary_sm2bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .binary_sm (binary_sm),
        .busy      (busy),
        .done      (done),
        .BCD       (BCD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits from integer arithmetic, sign placed by position
    function automatic logic [15:0] exp_bcd(input logic [7:0] sm);
        int         m;
        bit         n;
        int         p;
        logic [3:0] d[4];
        logic [3:0] lead;
`ifdef BINARY_SM2BCD_LEADING_BLANK_EN
        lead = 4'hF;
`else
        lead = 4'h0;
`endif
        if (sm == 8'h80) begin
            m = 128;
            n = 1'b1;
        end else begin
            m = int'(sm[6:0]);
            n = sm[7] && (m != 0);
        end
        d[0] = 4'(m % 10);
        d[1] = 4'((m / 10) % 10);
        d[2] = 4'(m / 100);
        d[3] = 4'h0;
        p = (d[2] != 0) ? 2 : (d[1] != 0) ? 1 : 0;
        if (n) begin
            p++;
            d[p] = 4'hE;
        end
        for (int i = p + 1; i < 4; i++) d[i] = lead;
        return {d[3], d[2], d[1], d[0]};
    endfunction

    // Output monitor: every done pops one expectation
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk_eq("spurious_done", 32'(BCD), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk_eq("bcd", 32'(BCD), 32'(e));
                $display("conv: BCD=%h expected=%h", BCD, e);
            end
        end
    end

    // One conversion; optionally pulses start again at N+3 and N+9
    task automatic run_conv(input logic [7:0] sm, input bit intrude);
        int k;
        bit got;
        int d0;
        d0 = n_done;
        @(negedge clk);
        binary_sm = sm;
        start     = 1'b1;
        exp_q.push_back(exp_bcd(sm));
        @(posedge clk);
        #1;
        start     = 1'b0;
        binary_sm = 8'($urandom);
        got = 1'b0;
        k   = 0;
        while (!got && k < 30) begin
            @(negedge clk);
            k++;
            if (k == 1) chk_eq("busy_after_start", 32'(busy), 32'd1);
            if (intrude && (k == 3 || k == 9)) begin
                start     = 1'b1;
                binary_sm = 8'h11;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk_eq("latency", 32'(k), 32'd11);
        chk_eq("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk_eq("done_one_cycle", 32'(done), 32'd0);
        if (intrude) begin
            repeat (14) @(negedge clk);
            chk_eq("single_done", 32'(n_done - d0), 32'd1);
        end
    endtask

    initial begin
        int d0;
        logic [7:0] vecs[10];
        n_vec     = 0;
        n_err     = 0;
        n_done    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        binary_sm = 8'h00;

        repeat (3) @(negedge clk);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_bcd", 32'(BCD), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs = '{8'd127, 8'h80, 8'hAA, 8'h85, 8'h00, 8'h0A, 8'h64, 8'h05, 8'hFF, 8'h8A};
        foreach (vecs[i]) run_conv(vecs[i], 1'b0);
        run_conv(8'h63, 1'b0);
        run_conv(8'h80 | 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) run_conv(8'($urandom), 1'b0);

        // Starts during a busy conversion are ignored
        run_conv(8'h4D, 1'b1);

        // Reset in the middle of a conversion
        d0 = n_done;
        @(negedge clk);
        binary_sm = 8'h33;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("abort_busy", 32'(busy), 32'd0);
        chk_eq("abort_done", 32'(done), 32'd0);
        chk_eq("abort_bcd", 32'(BCD), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk_eq("abort_no_done", 32'(n_done - d0), 32'd0);
        chk_eq("abort_bcd_hold", 32'(BCD), 32'd0);
        run_conv(8'h2D, 1'b0);
        run_conv(8'h81, 1'b0);

        repeat (3) @(negedge clk);
        chk_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_binary_sm2bcd
